ysyx_2022040010_pipe_ctrl: RTL and testbench

YSYX_2022040010_PIPE_CTRL -- requirements
Module: ysyx_2022040010_pipe_ctrl

---
 rtl/ysyx_2022040010_pipe_ctrl.sv | 117 +++++++++++
 tb/tb_ysyx_2022040010_pipe_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/ysyx_2022040010_pipe_ctrl.sv
// Pipeline hazard controller: per-stage hold/bubble, branch redirect, stage valid tracking.
// Optional stall watchdog enabled by defining YSYX_2022040010_STALL_WDT_EN.
module ysyx_2022040010_pipe_ctrl #(
  parameter int unsigned WDT_LIMIT = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] stall,
  input  logic       if_inst_valid,
  output logic [4:0] hold,
  output logic [4:0] bubble,
  output logic       pc_redirect,
  output logic [3:0] stage_valid,
  output logic       stall_timeout
);

  localparam int unsigned CntW = 16;

  typedef enum logic [2:0] {
    REQ_NONE,
    REQ_CACHE,
    REQ_EX,
    REQ_LOAD,
    REQ_FLUSH,
    REQ_RST
  } req_e;

  req_e req;
  logic pend_flush;
  logic pend_flush_nxt;

  // stall[5] (any-stall summary) and stall[4] carry no decision information
  logic unused_stall_bits;
  assign unused_stall_bits = ^stall[5:4];

  // Arbitration; a deferred flush overrides ex/load on the first cache-free cycle
  always_comb begin
    req = REQ_NONE;
    if (rst)             req = REQ_RST;
    else if (stall[3])   req = REQ_CACHE;
    else if (pend_flush) req = REQ_FLUSH;
    else if (stall[1])   req = REQ_EX;
    else if (stall[2])   req = REQ_FLUSH;
    else if (stall[0])   req = REQ_LOAD;
  end

  always_comb begin
    hold        = 5'b00000;
    bubble      = 5'b00000;
    pc_redirect = 1'b0;
    unique case (req)
      REQ_RST:   bubble = 5'b11111;
      REQ_CACHE: hold   = 5'b11111;
      REQ_EX: begin
        hold   = 5'b00111;
        bubble = 5'b01000;
      end
      REQ_LOAD: begin
        hold   = 5'b00011;
        bubble = 5'b00100;
      end
      REQ_FLUSH: begin
        bubble      = 5'b00010;
        pc_redirect = 1'b1;
      end
      default: ;
    endcase
  end

  // A branch flush seen under a cache stall is remembered until the cache releases
  always_comb begin
    pend_flush_nxt = 1'b0;
    if (stall[3]) pend_flush_nxt = pend_flush | stall[2];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_valid <= 4'b0000;
      pend_flush  <= 1'b0;
    end else begin
      pend_flush <= pend_flush_nxt;
      if (!hold[1]) stage_valid[0] <= if_inst_valid  & ~bubble[1];
      if (!hold[2]) stage_valid[1] <= stage_valid[0] & ~bubble[2];
      if (!hold[3]) stage_valid[2] <= stage_valid[1] & ~bubble[3];
      if (!hold[4]) stage_valid[3] <= stage_valid[2] & ~bubble[4];
    end
  end

`ifdef YSYX_2022040010_STALL_WDT_EN
  localparam logic [CntW-1:0] WdtMax = CntW'(WDT_LIMIT);

  logic [CntW-1:0] wdt_cnt;
  logic [CntW-1:0] wdt_cnt_nxt;

  // Saturating count of consecutive stalled cycles
  always_comb begin
    wdt_cnt_nxt = (wdt_cnt == WdtMax) ? wdt_cnt : wdt_cnt + CntW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wdt_cnt       <= '0;
      stall_timeout <= 1'b0;
    end else if (|stall[3:0]) begin
      wdt_cnt <= wdt_cnt_nxt;
      if (wdt_cnt_nxt == WdtMax) stall_timeout <= 1'b1;
    end else begin
      wdt_cnt <= '0;
    end
  end
`else
  logic [CntW-1:0] unused_limit;
  assign unused_limit  = CntW'(WDT_LIMIT);
  assign stall_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_2022040010_pipe_ctrl.sv
// Directed + randomized bench for ysyx_2022040010_pipe_ctrl against a per-cycle reference model.
module tb_ysyx_2022040010_pipe_ctrl;

  localparam int unsigned LIMIT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] stall = '0;
  logic       if_inst_valid = 1'b0;
  logic [4:0] hold;
  logic [4:0] bubble;
  logic       pc_redirect;
  logic [3:0] stage_valid;
  logic       stall_timeout;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [3:0] mv = '0;
  logic       mpend = 1'b0;
  int         mcnt = 0;
  logic       mto = 1'b0;

  ysyx_2022040010_pipe_ctrl #(.WDT_LIMIT(LIMIT)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .if_inst_valid(if_inst_valid),
    .hold         (hold),
    .bubble       (bubble),
    .pc_redirect  (pc_redirect),
    .stage_valid  (stage_valid),
    .stall_timeout(stall_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  // One clock: drive, check combinational controls, clock, check registered state
  task automatic cycle(input logic [5:0] st, input logic ifv, input logic r);
    logic [4:0] eh, eb;
    logic       er;
    logic [3:0] src;
    stall = st; if_inst_valid = ifv; rst = r;
    #1;
    eh = 5'b00000; eb = 5'b00000; er = 1'b0;
    if (r) eb = 5'b11111;
    else if (st[3]) eh = 5'b11111;
    else if (mpend || (st[2] && !st[1])) begin eb = 5'b00010; er = 1'b1; end
    else if (st[1]) begin eh = 5'b00111; eb = 5'b01000; end
    else if (st[0]) begin eh = 5'b00011; eb = 5'b00100; end
    chk("hold", hold, eh);
    chk("bubble", bubble, eb);
    chk("pc_redirect", 5'(pc_redirect), 5'(er));
    @(posedge clk);
    if (r) begin
      mv = '0; mpend = 1'b0; mcnt = 0; mto = 1'b0;
    end else begin
      src = {mv[2:0], ifv};
      for (int s = 1; s <= 4; s++)
        if (!eh[s]) mv[s-1] = src[s-1] & ~eb[s];
      mpend = st[3] ? (mpend | st[2]) : 1'b0;
      if (st[3:0] != 4'b0000) begin
        if (mcnt < int'(LIMIT)) mcnt = mcnt + 1;
        if (mcnt == int'(LIMIT)) mto = 1'b1;
      end else mcnt = 0;
    end
    #1;
    chk("stage_valid", 5'(stage_valid), 5'(mv));
`ifdef YSYX_2022040010_STALL_WDT_EN
    chk("stall_timeout", 5'(stall_timeout), 5'(mto));
`else
    chk("stall_timeout", 5'(stall_timeout), 5'b0);
`endif
  endtask

  initial begin
    logic [5:0] st;
    // reset
    cycle(6'b000000, 1'b1, 1'b1);
    chk("reset_valid", 5'(stage_valid), 5'b0);
    // cache stall three cycles, then advance
    for (int i = 0; i < 3; i++) begin
      cycle(6'b101000, 1'b1, 1'b0);
      chk("cache_hold", hold, 5'b11111);
    end
    for (int i = 0; i < 4; i++) cycle(6'b000000, 1'b1, 1'b0);
    chk("all_valid", 5'(stage_valid), 5'b01111);
    // load-use
    cycle(6'b100001, 1'b1, 1'b0);
    chk("load_valid", 5'(stage_valid), 5'b01101);
    // cache + bru, then release: one redirect only
    cycle(6'b101100, 1'b1, 1'b0);
    cycle(6'b101100, 1'b1, 1'b0);
    chk("deferred_no_redirect", 5'(pc_redirect), 5'b0);
    cycle(6'b000000, 1'b1, 1'b0);
    cycle(6'b000000, 1'b1, 1'b0);
    // deferred flush coinciding with a fresh bru
    cycle(6'b101100, 1'b1, 1'b0);
    cycle(6'b100100, 1'b1, 1'b0);
    cycle(6'b000000, 1'b1, 1'b0);
    // bru + load
    cycle(6'b100101, 1'b1, 1'b0);
    cycle(6'b000000, 1'b1, 1'b0);
    // stall[5]/[4] ignored, stall[3:0] honoured without stall[5]
    cycle(6'b110000, 1'b1, 1'b0);
    cycle(6'b000010, 1'b1, 1'b0);
    cycle(6'b011000, 1'b0, 1'b0);
    // watchdog: ex stall held LIMIT cycles after reset
    cycle(6'b000000, 1'b1, 1'b1);
    for (int i = 0; i < int'(LIMIT); i++) cycle(6'b100010, 1'b1, 1'b0);
    cycle(6'b000000, 1'b1, 1'b0);
    cycle(6'b000000, 1'b1, 1'b0);
    cycle(6'b000000, 1'b0, 1'b1);
    // reset with a flush pending
    cycle(6'b101100, 1'b1, 1'b0);
    cycle(6'b101100, 1'b1, 1'b1);
    cycle(6'b000000, 1'b0, 1'b0);
    chk("post_reset_redirect", 5'(pc_redirect), 5'b0);
    chk("post_reset_valid", 5'(stage_valid), 5'b0);
    // randomized
    for (int i = 0; i < 400; i++) begin
      st = 6'($urandom);
      if ($urandom_range(0, 2) != 0) st[3] = 1'b0;
      if ($urandom_range(0, 1) != 0) st[1] = 1'b0;
      if ($urandom_range(0, 2) == 0) st[3:0] = 4'b0000;
      cycle(st, 1'($urandom), 1'($urandom_range(0, 39) == 0));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
